// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the period meter and the clock divider it checks.
package clk_pkg;

    // Counter width shared with the divider so divBy and div_est line up.
    localparam int CLK_CNT_W = 26;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Divide value that reproduces a measured phase length; 0 stays 0.
    function automatic logic [CLK_CNT_W-1:0] phase_to_div(input logic [CLK_CNT_W-1:0] ph);
        return (ph == '0) ? '0 : ph - 1'b1;
    endfunction

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Multi-flop synchroniser with registered rise/fall strobes.
// The synchroniser and history flop always sample; only the strobes are gated.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the input through the synchroniser and compare against history.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            hist_q <= synced;
            rise_q <= en_i &  synced & ~hist_q;
            fall_q <= en_i & ~synced &  hist_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high phase, low phase and period of a slow input in clkin cycles.
module clock_period_meter
    import clk_pkg::*;
#(
    parameter int               CNT_W       = CLK_CNT_W,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}}
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             measure_en,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] low_count,
    output logic [CNT_W:0]   period,
    output logic [CNT_W-1:0] div_est,
    output logic             meas_valid,
    output logic             locked,
    output logic             stalled
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic [CNT_W-1:0] div_q;
    logic             mv_q, mv_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;
    logic             rise, fall, edge_seen, tmo;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clkin),
        .reset_i (reset),
        .sig_i   (sig_in),
        .en_i    (measure_en),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign edge_seen = rise | fall;
    // An edge on the timeout cycle takes priority over the stall.
    assign tmo       = (cnt_q == TIMEOUT) && !edge_seen;

    // Next-state, phase counter and result latching.
    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        low_d     = low_q;
        period_d  = period_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        stalled_d = stalled_q;
        if (edge_seen)
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (cnt_q == {CNT_W{1'b1}})
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        if (!measure_en) begin
            state_d   = ACQ;
            cnt_d     = '0;
            locked_d  = 1'b0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                ACQ: begin
                    if (rise) state_d = HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        high_d  = cnt_q;
                        state_d = LOW;
                    end else if (tmo) begin
                        state_d   = ACQ;
                        stalled_d = 1'b1;
                        locked_d  = 1'b0;
                    end
                end
                LOW: begin
                    if (rise) begin
                        low_d     = cnt_q;
                        period_d  = {1'b0, high_q} + {1'b0, cnt_q};
                        mv_d      = 1'b1;
                        locked_d  = 1'b1;
                        stalled_d = 1'b0;
                        state_d   = HIGH;
                    end else if (tmo) begin
                        state_d   = ACQ;
                        stalled_d = 1'b1;
                        locked_d  = 1'b0;
                    end
                end
                default: state_d = ACQ;
            endcase
        end
    end

    // State and result registers; reset clears everything mid-measurement.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q   <= ACQ;
            cnt_q     <= '0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            div_q     <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            low_q     <= low_d;
            period_q  <= period_d;
            div_q     <= phase_to_div(high_q);
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            stalled_q <= stalled_d;
        end
    end

    assign rise_pulse = rise;
    assign fall_pulse = fall;
    assign high_count = high_q;
    assign low_count  = low_q;
    assign period     = period_q;
    assign div_est    = div_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench: a divider model toggles sig_in with programmable phases.
module tb_clock_period_meter;

    localparam int W = 26;

    logic         clkin = 1'b0;
    logic         reset;
    logic         sig_in;
    logic         measure_en;
    logic         rise_pulse, fall_pulse;
    logic [W-1:0] high_count, low_count, div_est;
    logic [W:0]   period;
    logic         meas_valid, locked, stalled;

    int  total = 0;
    int  bad   = 0;
    int  hi_len = 4;
    int  lo_len = 4;
    bit  gen_on = 0;
    bit  saw_stall;
    int  rises, cnt_ev;
    bit  got;

    clock_period_meter #(.CNT_W(W), .SYNC_STAGES(2), .TIMEOUT(26'd100)) dut (
        .clkin      (clkin),
        .reset      (reset),
        .sig_in     (sig_in),
        .measure_en (measure_en),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .high_count (high_count),
        .low_count  (low_count),
        .period     (period),
        .div_est    (div_est),
        .meas_valid (meas_valid),
        .locked     (locked),
        .stalled    (stalled)
    );

    always #5 clkin = ~clkin;

    // Divider model: sig_in stays high hi_len cycles and low lo_len cycles.
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge clkin);
            #1;
            if (!gen_on) begin
                ph = 0;
            end else begin
                ph++;
                if (sig_in ? (ph >= hi_len) : (ph >= lo_len)) begin
                    sig_in = ~sig_in;
                    ph = 0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clkin);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step until meas_valid is seen, counting rise strobes on the way.
    task automatic wait_mv(input int budget, output int nr, output bit ok);
        nr = 0;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rise_pulse) nr++;
            if (stalled) saw_stall = 1;
            if (meas_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_rise(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rise_pulse) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        measure_en = 1'b1;
        repeat (3) tick();
        check("reset_counts", high_count | low_count | div_est | period[W-1:0], 32'd0);
        check("reset_flags", {27'd0, period[W], meas_valid, locked, stalled, rise_pulse | fall_pulse}, 32'd0);
        reset = 1'b0;

        // divBy=3: 4-cycle phases
        hi_len = 4; lo_len = 4; gen_on = 1;
        wait_mv(100, rises, got);
        check("t1_mv_seen", got, 1);
        check("t1_rises_before_mv", rises, 2);
        check("t1_high", high_count, 4);
        check("t1_low", low_count, 4);
        check("t1_period", period, 8);
        check("t1_div_est", div_est, 3);
        check("t1_locked", locked, 1);
        repeat (3) tick();
        check("t1_fall_spacing", fall_pulse, 1);
        repeat (4) tick();
        check("t1_mv_gap_low", meas_valid, 0);
        tick();
        check("t1_mv_every_8", meas_valid, 1);

        // asymmetric 5/9
        hi_len = 5; lo_len = 9;
        wait_mv(100, rises, got);
        wait_mv(100, rises, got);
        check("t2_mv_seen", got, 1);
        check("t2_high", high_count, 5);
        check("t2_low", low_count, 9);
        check("t2_period", period, 14);
        check("t2_div_est", div_est, 4);

        // stall: hold sig_in high after a rise
        hi_len = 4; lo_len = 4;
        wait_mv(100, rises, got);
        wait_mv(100, rises, got);
        check("t3_period_before", period, 8);
        wait_rise(100, got);
        check("t3_rise_seen", got, 1);
        gen_on = 0;
        repeat (99) tick();
        check("t3_not_stalled_yet", stalled, 0);
        repeat (2) tick();
        check("t3_stalled", stalled, 1);
        check("t3_unlocked", locked, 0);
        check("t3_period_hold", period, 8);
        check("t3_high_hold", high_count, 4);
        gen_on = 1;
        wait_mv(100, rises, got);
        check("t3_resume_mv", got, 1);
        check("t3_stall_cleared", stalled, 0);
        check("t3_resume_period", period, 8);

        // high phase of exactly TIMEOUT cycles: edge wins
        hi_len = 100; lo_len = 4;
        wait_mv(400, rises, got);
        saw_stall = 0;
        wait_mv(400, rises, got);
        check("t4_mv_seen", got, 1);
        check("t4_no_stall", saw_stall, 0);
        check("t4_high", high_count, 100);
        check("t4_period", period, 104);

        // divBy=7, reset mid-LOW
        hi_len = 8; lo_len = 8;
        wait_mv(100, rises, got);
        wait_mv(100, rises, got);
        check("t5_period_before", period, 16);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fall_pulse) break;
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_reset_counts", high_count | low_count | div_est | period[W-1:0], 32'd0);
        check("t5_reset_flags", {27'd0, period[W], meas_valid, locked, stalled, rise_pulse | fall_pulse}, 32'd0);
        wait_mv(100, rises, got);
        check("t5_mv_seen", got, 1);
        check("t5_rises_before_mv", rises, 2);
        check("t5_period", period, 16);

        // measure_en low for 50 cycles while locked
        hi_len = 4; lo_len = 4;
        wait_mv(100, rises, got);
        wait_mv(100, rises, got);
        check("t6_period_before", period, 8);
        measure_en = 1'b0;
        cnt_ev = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rise_pulse | fall_pulse | meas_valid | stalled) cnt_ev++;
        end
        check("t6_no_events", cnt_ev, 0);
        check("t6_unlocked", locked, 0);
        check("t6_period_hold", period, 8);
        measure_en = 1'b1;
        wait_mv(100, rises, got);
        check("t6_reenable_mv", got, 1);
        check("t6_reenable_period", period, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
